// File: rtl/cache_pkg.sv
// Shared types and address helpers for the fetch-stage instruction cache.
// Default geometry is 32 sets of 4-word blocks; the controller may override it.
package cache_pkg;

   typedef enum logic [1:0] {IDLE, REQ, FILL} icache_state_t;

   localparam int unsigned ICACHE_SETS  = 32;
   localparam int unsigned ICACHE_WORDS = 4;
   localparam int unsigned OFF_W        = $clog2(ICACHE_WORDS);
   localparam int unsigned IDX_W        = $clog2(ICACHE_SETS);
   localparam int unsigned TAG_W        = 32 - IDX_W - OFF_W - 2;

   // Clears the byte and word-offset bits so the address points at the start of its block.
   function automatic logic [31:0] block_align(input logic [31:0] addr, input int unsigned words);
      return addr & ~((32'(words) << 2) - 32'd1);
   endfunction

endpackage

// File: rtl/icache_data_array.sv
// S x B x 32-bit instruction storage: one synchronous write port, one combinational read port.
// Contents are not reset; validity is tracked by the controller.
module icache_data_array #(
   parameter int unsigned S = 32,
   parameter int unsigned B = 4
) (
   input  logic                   clk,
   input  logic                   wr_en_i,
   input  logic [$clog2(S)-1:0]   wr_set_i,
   input  logic [$clog2(B)-1:0]   wr_word_i,
   input  logic [31:0]            wr_data_i,
   input  logic [$clog2(S)-1:0]   rd_set_i,
   input  logic [$clog2(B)-1:0]   rd_word_i,
   output logic [31:0]            rd_data_o
);

   logic [31:0] mem_q [S*B];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[{wr_set_i, wr_word_i}] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[{rd_set_i, rd_word_i}];

endmodule

// File: rtl/instr_cache_ctlr.sv
// Direct-mapped blocking instruction cache: same-cycle lookup, one refill at a time.
// Miss raises InstrMissF and runs REQ -> FILL; lines become valid only after the final beat.
module instr_cache_ctlr
   import cache_pkg::*;
#(
   parameter int unsigned S = ICACHE_SETS,
   parameter int unsigned B = ICACHE_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   output logic [31:0] InstrF,
   output logic        InstrMissF,
   output logic        InstrCacheRepActive,
   output logic        MemReqValid,
   output logic [31:0] MemReqAddr,
   input  logic        MemReqReady,
   input  logic        MemRspValid,
   input  logic [31:0] MemRspData
);

   localparam int OW = $clog2(B);
   localparam int IW = $clog2(S);
   localparam int TW = 32 - IW - OW - 2;

   icache_state_t   state_q, state_d;
   logic [OW-1:0]   beat_q, beat_d;
   logic [31:0]     miss_addr_q, miss_addr_d;
   logic [S-1:0]    valid_q, valid_d;
   logic [TW-1:0]   tag_q [S];

   logic [OW-1:0]   pc_off;
   logic [IW-1:0]   pc_idx;
   logic [TW-1:0]   pc_tag;
   logic [IW-1:0]   miss_idx;
   logic [TW-1:0]   miss_tag;
   logic            hit;
   logic            fill_we;
   logic            tag_we;
   logic            unused_pc_lsb;

   assign pc_off        = PCF[OW+1:2];
   assign pc_idx        = PCF[OW+2 +: IW];
   assign pc_tag        = PCF[31 -: TW];
   assign unused_pc_lsb = ^PCF[1:0];
   assign miss_idx      = miss_addr_q[OW+2 +: IW];
   assign miss_tag      = miss_addr_q[31 -: TW];
   assign hit           = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

   always_comb begin
      state_d             = state_q;
      beat_d              = beat_q;
      miss_addr_d         = miss_addr_q;
      valid_d             = valid_q;
      fill_we             = 1'b0;
      tag_we              = 1'b0;
      MemReqValid         = 1'b0;
      InstrCacheRepActive = 1'b0;
      InstrMissF          = ~hit;
      case (state_q)
         IDLE: begin
            if (!hit) begin
               miss_addr_d = block_align(PCF, B);
               state_d     = REQ;
            end
         end
         REQ: begin
            MemReqValid         = 1'b1;
            InstrCacheRepActive = 1'b1;
            InstrMissF          = 1'b1;
            if (MemReqReady) begin
               // The old line at this index is gone from here on, even if the tag still matches.
               beat_d            = '0;
               valid_d[miss_idx] = 1'b0;
               state_d           = FILL;
            end
         end
         FILL: begin
            InstrCacheRepActive = 1'b1;
            InstrMissF          = 1'b1;
            if (MemRspValid) begin
               fill_we = 1'b1;
               beat_d  = beat_q + OW'(1);
               if (beat_q == OW'(B - 1)) begin
                  tag_we            = 1'b1;
                  valid_d[miss_idx] = 1'b1;
                  state_d           = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign MemReqAddr = (state_q == REQ) ? miss_addr_q : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         miss_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we && !reset) begin
         tag_q[miss_idx] <= miss_tag;
      end
   end

   icache_data_array #(.S(S), .B(B)) u_data (
      .clk       (clk),
      .wr_en_i   (fill_we && !reset),
      .wr_set_i  (miss_idx),
      .wr_word_i (beat_q),
      .wr_data_i (MemRspData),
      .rd_set_i  (pc_idx),
      .rd_word_i (pc_off),
      .rd_data_o (InstrF)
   );

endmodule

// File: tb/tb_instr_cache_ctlr.sv
// Directed bench for instr_cache_ctlr (S=32, B=4): refill timing, gaps, conflicts, redirect, reset.
module tb_instr_cache_ctlr;

   logic        clk;
   logic        reset;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        InstrMissF;
   logic        InstrCacheRepActive;
   logic        MemReqValid;
   logic [31:0] MemReqAddr;
   logic        MemReqReady;
   logic        MemRspValid;
   logic [31:0] MemRspData;

   int tests_run;
   int tests_failed;

   instr_cache_ctlr #(.S(32), .B(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .PCF                 (PCF),
      .InstrF              (InstrF),
      .InstrMissF          (InstrMissF),
      .InstrCacheRepActive (InstrCacheRepActive),
      .MemReqValid         (MemReqValid),
      .MemReqAddr          (MemReqAddr),
      .MemReqReady         (MemReqReady),
      .MemRspValid         (MemRspValid),
      .MemRspData          (MemRspData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Backing-memory contents: upper half is the address, lower half its complement.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      MemRspValid = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Drives n FILL-phase cycles; bit i of pat is RspValid in cycle i. Beats count up from first_beat.
   task automatic feed(input logic [31:0] base, input int first_beat, input logic [7:0] pat, input int n);
      int k;
      k = first_beat;
      for (int i = 0; i < n; i++) begin
         MemRspValid = pat[i];
         MemRspData  = pat[i] ? word_at(base + 32'(4 * k)) : 32'hBAD0_BAD0;
         if (pat[i]) k++;
         step();
      end
      MemRspValid = 1'b0;
      MemRspData  = 32'h0;
   endtask

   task automatic test_reset();
      PCF = 32'h40; MemReqReady = 1'b0;
      apply_reset();
      #1;
      tests_run++; if (InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL reset_miss: got %b want 1", InstrMissF); end
      tests_run++; if (MemReqValid !== 1'b0) begin tests_failed++; $display("FAIL reset_reqvld: got %b want 0", MemReqValid); end
      tests_run++; if (MemReqAddr !== 32'h0) begin tests_failed++; $display("FAIL reset_reqaddr: got %h want 0", MemReqAddr); end
      tests_run++; if (InstrCacheRepActive !== 1'b0) begin tests_failed++; $display("FAIL reset_rep: got %b want 0", InstrCacheRepActive); end
   endtask

   task automatic test_cold_start();
      apply_reset();
      PCF = 32'h40; MemReqReady = 1'b1;
      #1;
      tests_run++; if (MemReqValid !== 1'b0 || InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL cold_c0: reqvld=%b miss=%b want 0/1", MemReqValid, InstrMissF); end
      step(); #1;
      tests_run++; if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h40) begin tests_failed++; $display("FAIL cold_req: reqvld=%b addr=%h want 1/00000040", MemReqValid, MemReqAddr); end
      tests_run++; if (InstrCacheRepActive !== 1'b1 || InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL cold_req_flags: rep=%b miss=%b want 1/1", InstrCacheRepActive, InstrMissF); end
      step(); #1;
      tests_run++; if (MemReqValid !== 1'b0 || InstrCacheRepActive !== 1'b1) begin tests_failed++; $display("FAIL cold_fill: reqvld=%b rep=%b want 0/1", MemReqValid, InstrCacheRepActive); end
      feed(32'h40, 0, 8'h0F, 4);
      #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h0040_FFBF) begin tests_failed++; $display("FAIL cold_hit_c6: miss=%b instr=%h want 0/0040ffbf", InstrMissF, InstrF); end
      tests_run++; if (InstrCacheRepActive !== 1'b0) begin tests_failed++; $display("FAIL cold_rep_done: got %b want 0", InstrCacheRepActive); end
      PCF = 32'h4C; #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h004C_FFB3) begin tests_failed++; $display("FAIL cold_word3: miss=%b instr=%h want 0/004cffb3", InstrMissF, InstrF); end
   endtask

   task automatic test_ready_delay();
      apply_reset();
      PCF = 32'h80; MemReqReady = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h80) begin tests_failed++; $display("FAIL rdy_hold%0d: reqvld=%b addr=%h want 1/00000080", i, MemReqValid, MemReqAddr); end
         step();
      end
      MemReqReady = 1'b1; #1;
      tests_run++; if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h80) begin tests_failed++; $display("FAIL rdy_grant: reqvld=%b addr=%h want 1/00000080", MemReqValid, MemReqAddr); end
      step(); #1;
      tests_run++; if (MemReqValid !== 1'b0 || InstrCacheRepActive !== 1'b1) begin tests_failed++; $display("FAIL rdy_fill: reqvld=%b rep=%b want 0/1", MemReqValid, InstrCacheRepActive); end
      feed(32'h80, 0, 8'h0F, 4);
      #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h0080_FF7F) begin tests_failed++; $display("FAIL rdy_hit: miss=%b instr=%h want 0/0080ff7f", InstrMissF, InstrF); end
   endtask

   task automatic test_rsp_gaps();
      apply_reset();
      PCF = 32'hC0; MemReqReady = 1'b1;
      step(); step();
      feed(32'hC0, 0, 8'b0000_1001, 4);
      #1;
      tests_run++; if (InstrMissF !== 1'b1 || InstrCacheRepActive !== 1'b1) begin tests_failed++; $display("FAIL gap_partial: miss=%b rep=%b want 1/1", InstrMissF, InstrCacheRepActive); end
      feed(32'hC0, 2, 8'b0000_0101, 3);
      for (int w = 0; w < 4; w++) begin
         PCF = 32'hC0 + 32'(4 * w); #1;
         tests_run++; if (InstrMissF !== 1'b0 || InstrF !== word_at(PCF)) begin tests_failed++; $display("FAIL gap_word%0d: miss=%b instr=%h want 0/%h", w, InstrMissF, InstrF, word_at(PCF)); end
      end
   endtask

   task automatic test_conflict();
      MemReqReady = 1'b1;
      PCF = 32'h40; #1;
      step(); step();
      feed(32'h40, 0, 8'h0F, 4);
      #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h0040_FFBF) begin tests_failed++; $display("FAIL conf_first: miss=%b instr=%h want 0/0040ffbf", InstrMissF, InstrF); end
      PCF = 32'h240; #1;
      tests_run++; if (InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL conf_miss: got %b want 1", InstrMissF); end
      step(); #1;
      tests_run++; if (MemReqAddr !== 32'h240) begin tests_failed++; $display("FAIL conf_addr: got %h want 00000240", MemReqAddr); end
      step();
      feed(32'h240, 0, 8'h0F, 4);
      #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h0240_FDBF) begin tests_failed++; $display("FAIL conf_new: miss=%b instr=%h want 0/0240fdbf", InstrMissF, InstrF); end
      PCF = 32'h40; #1;
      tests_run++; if (InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL conf_evicted: got %b want 1", InstrMissF); end
      step(); step();
      feed(32'h40, 0, 8'h0F, 4);
   endtask

   task automatic test_redirect();
      apply_reset();
      PCF = 32'h240; MemReqReady = 1'b1; #1;
      tests_run++; if (InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL redir_cleared: got %b want 1", InstrMissF); end
      PCF = 32'h40;
      step(); step();
      feed(32'h40, 0, 8'h03, 2);
      PCF = 32'h100; #1;
      tests_run++; if (InstrMissF !== 1'b1 || InstrCacheRepActive !== 1'b1) begin tests_failed++; $display("FAIL redir_mid: miss=%b rep=%b want 1/1", InstrMissF, InstrCacheRepActive); end
      feed(32'h40, 2, 8'h03, 2);
      #1;
      tests_run++; if (InstrMissF !== 1'b1 || InstrCacheRepActive !== 1'b0 || MemReqValid !== 1'b0) begin tests_failed++; $display("FAIL redir_idle: miss=%b rep=%b reqvld=%b want 1/0/0", InstrMissF, InstrCacheRepActive, MemReqValid); end
      step(); #1;
      tests_run++; if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h100) begin tests_failed++; $display("FAIL redir_req2: reqvld=%b addr=%h want 1/00000100", MemReqValid, MemReqAddr); end
      step();
      feed(32'h100, 0, 8'h0F, 4);
      #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h0100_FEFF) begin tests_failed++; $display("FAIL redir_hit2: miss=%b instr=%h want 0/0100feff", InstrMissF, InstrF); end
      PCF = 32'h44; #1;
      tests_run++; if (InstrMissF !== 1'b0 || InstrF !== 32'h0044_FFBB) begin tests_failed++; $display("FAIL redir_old_line: miss=%b instr=%h want 0/0044ffbb", InstrMissF, InstrF); end
   endtask

   task automatic test_reset_mid_fill();
      apply_reset();
      PCF = 32'h40; MemReqReady = 1'b1;
      step(); step();
      feed(32'h40, 0, 8'h03, 2);
      MemReqReady = 1'b0;
      apply_reset();
      #1;
      tests_run++; if (InstrMissF !== 1'b1 || MemReqValid !== 1'b0 || InstrCacheRepActive !== 1'b0 || MemReqAddr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_state: miss=%b reqvld=%b rep=%b addr=%h want 1/0/0/0", InstrMissF, MemReqValid, InstrCacheRepActive, MemReqAddr); end
      MemRspValid = 1'b1; MemRspData = 32'hDEAD_BEEF;
      step(); step();
      MemRspValid = 1'b0; #1;
      tests_run++; if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h40 || InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL rstmid_late: reqvld=%b addr=%h miss=%b want 1/00000040/1", MemReqValid, MemReqAddr, InstrMissF); end
      MemReqReady = 1'b1;
      step(); #1;
      tests_run++; if (InstrCacheRepActive !== 1'b1 || MemReqValid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_fill: rep=%b reqvld=%b want 1/0", InstrCacheRepActive, MemReqValid); end
      feed(32'h40, 0, 8'h07, 3);
      #1;
      tests_run++; if (InstrMissF !== 1'b1) begin tests_failed++; $display("FAIL rstmid_3beats: got %b want 1", InstrMissF); end
      feed(32'h40, 3, 8'h01, 1);
      for (int w = 0; w < 4; w++) begin
         PCF = 32'h40 + 32'(4 * w); #1;
         tests_run++; if (InstrMissF !== 1'b0 || InstrF !== word_at(PCF)) begin tests_failed++; $display("FAIL rstmid_word%0d: miss=%b instr=%h want 0/%h", w, InstrMissF, InstrF, word_at(PCF)); end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      PCF          = 32'h0;
      MemReqReady  = 1'b0;
      MemRspValid  = 1'b0;
      MemRspData   = 32'h0;
      test_reset();
      test_cold_start();
      test_ready_delay();
      test_rsp_gaps();
      test_conflict();
      test_redirect();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
